montgomery_exp_ctrl: RTL and testbench



---
 rtl/montgomery_exp_ctrl.sv | 149 ++++++++++++++
 tb/tb_montgomery_exp_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply controller computing x^e mod m through an external Montgomery multiplier.
// Optional build macro SKIP_LEADING_ZEROS_EN: skip leading zero exponent bits before entering the Montgomery domain.
module montgomery_exp_ctrl #(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r_mod_m,
  input  logic [WIDTH-1:0]     in_r2_mod_m,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_m,
  input  logic [WIDTH:0]       mul_result,
  input  logic                 mul_done,
  output logic                 mul_err
);
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IW-1:0]    TOP_BIT = IW'(EXP_WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_TOMONT_I = 4'd1;
  localparam logic [3:0] S_TOMONT_W = 4'd2;
  localparam logic [3:0] S_SQR_I    = 4'd3;
  localparam logic [3:0] S_SQR_W    = 4'd4;
  localparam logic [3:0] S_MUL_I    = 4'd5;
  localparam logic [3:0] S_MUL_W    = 4'd6;
  localparam logic [3:0] S_NEXT     = 4'd7;
  localparam logic [3:0] S_FROM_I   = 4'd8;
  localparam logic [3:0] S_FROM_W   = 4'd9;
  localparam logic [3:0] S_DONE     = 4'd10;
`ifdef SKIP_LEADING_ZEROS_EN
  localparam logic [3:0] S_SCAN     = 4'd11;
`endif

  logic [3:0]           state;
  logic [WIDTH-1:0]     x_r, m_r, r_r, r2_r, xm, acc;
  logic [EXP_WIDTH-1:0] e_r;
  logic [IW-1:0]        idx;
  logic [WIDTH-1:0]     prod;
  logic                 in_wait, cap;

  assign prod      = mul_result[WIDTH-1:0];
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mul_m     = m_r;
  assign mul_start = (state == S_TOMONT_I) || (state == S_SQR_I) ||
                     (state == S_MUL_I)    || (state == S_FROM_I);
  assign in_wait   = (state == S_TOMONT_W) || (state == S_SQR_W) ||
                     (state == S_MUL_W)    || (state == S_FROM_W);
  assign cap       = in_wait && mul_done;

  // Operands decode from state and registers that only change on capture,
  // so they hold from the issue cycle through the done cycle.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_TOMONT_I, S_TOMONT_W: begin mul_a = x_r; mul_b = r2_r; end
      S_SQR_I,    S_SQR_W:    begin mul_a = acc; mul_b = acc;  end
      S_MUL_I,    S_MUL_W:    begin mul_a = acc; mul_b = xm;   end
      S_FROM_I,   S_FROM_W:   begin mul_a = acc; mul_b = ONE;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      x_r     <= '0;
      e_r     <= '0;
      m_r     <= '0;
      r_r     <= '0;
      r2_r    <= '0;
      xm      <= '0;
      acc     <= '0;
      idx     <= '0;
      result  <= '0;
      mul_err <= 1'b0;
    end else begin
      if (cap && mul_result[WIDTH]) mul_err <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          x_r     <= in_x;
          e_r     <= in_e;
          m_r     <= in_m;
          r_r     <= in_r_mod_m;
          r2_r    <= in_r2_mod_m;
          idx     <= TOP_BIT;
          mul_err <= 1'b0;
`ifdef SKIP_LEADING_ZEROS_EN
          state   <= S_SCAN;
`else
          state   <= S_TOMONT_I;
`endif
        end
`ifdef SKIP_LEADING_ZEROS_EN
        // e = 0 needs only the final conversion of Montgomery one (R mod m).
        S_SCAN: begin
          if (!e_r[idx] && (idx != '0)) idx <= idx - IW'(1);
          else if (!e_r[idx]) begin
            acc   <= r_r;
            state <= S_FROM_I;
          end else state <= S_TOMONT_I;
        end
`endif
        S_TOMONT_I: state <= S_TOMONT_W;
        S_TOMONT_W: if (mul_done) begin
          xm    <= prod;
          acc   <= r_r;
          state <= S_SQR_I;
        end
        S_SQR_I: state <= S_SQR_W;
        S_SQR_W: if (mul_done) begin
          acc   <= prod;
          state <= e_r[idx] ? S_MUL_I : S_NEXT;
        end
        S_MUL_I: state <= S_MUL_W;
        S_MUL_W: if (mul_done) begin
          acc   <= prod;
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (idx == '0) state <= S_FROM_I;
          else begin
            idx   <= idx - IW'(1);
            state <= S_SQR_I;
          end
        end
        S_FROM_I: state <= S_FROM_W;
        S_FROM_W: if (mul_done) begin
          result <= prod;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Directed bench for montgomery_exp_ctrl with a behavioural MontMul responder (m=13, R=2^16).
module tb_montgomery_exp_ctrl;
  localparam int W = 16, EW = 8;
  localparam logic [W-1:0] M = 16'd13, RM = 16'd3, R2 = 16'd9, RINV = 16'd9; // 3*9 = 27 = 1 mod 13
`ifdef SKIP_LEADING_ZEROS_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0]  in_x = '0;
  logic [EW-1:0] in_e = '0;
  logic busy, done, mul_start, mul_err;
  logic [W-1:0] result, mul_a, mul_b, mul_m;
  logic [W:0] mul_result = '0;
  logic mul_done = 1'b0;

  int checks = 0, passed = 0;
  bit pend = 0, inj = 0;
  int cnt = 0, lat_cfg = 1, nstart = 0, proto_err = 0, stab_err = 0;
  logic [W-1:0] la = '0, lb = '0;

  montgomery_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_x(in_x), .in_e(in_e), .in_m(M),
    .in_r_mod_m(RM), .in_r2_mod_m(R2), .busy(busy), .done(done), .result(result),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_result(mul_result), .mul_done(mul_done), .mul_err(mul_err));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = (longint'(a) * longint'(b) % longint'(M)) * longint'(RINV) % longint'(M);
    return W'(p);
  endfunction

  // Responder: sees mul_start mid-cycle, answers after lat_cfg cycles (0 = random 1..50).
  always @(negedge clk) begin
    mul_done = 1'b0;
    if (pend) begin
      if (mul_start) proto_err++;
      if (busy && (mul_a !== la || mul_b !== lb)) stab_err++;
      cnt--;
      if (cnt <= 0) begin
        mul_result = {inj, mont(la, lb)};
        inj = 1'b0;
        mul_done = 1'b1;
        pend = 1'b0;
      end
    end else if (mul_start) begin
      pend = 1'b1;
      la = mul_a;
      lb = mul_b;
      nstart++;
      cnt = (lat_cfg == 0) ? int'($urandom_range(50, 1)) : lat_cfg;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [EW-1:0] e, input int lat,
                        input bit poke_busy, input bit poke_done, input bit do_inj,
                        input logic [W-1:0] prev, input logic [W-1:0] exp_res,
                        input int exp_mul, input bit exp_err);
    int cyc, ndone;
    lat_cfg = lat;
    @(negedge clk);
    nstart = 0;
    inj = do_inj;
    in_x = x;
    in_e = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_clear_on_start", mul_err, 0);
    chk("result_held_into_next", result, prev);
    chk("mul_m", mul_m, M);
    cyc = 0;
    ndone = 0;
    while (ndone == 0 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) ndone++;
      else if (poke_busy && cyc == 3) begin
        in_x = x + 16'd3;
        start = 1'b1;
      end
    end
    chk("done_seen", ndone, 1);
    chk("result", result, exp_res);
    chk("mul_count", nstart, exp_mul);
    if (poke_done) begin
      in_x = x + 16'd5;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_done", busy, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("single_done", ndone, 1);
    chk("result_held", result, exp_res);
    chk("mul_err", mul_err, exp_err);
  endtask

  typedef struct {
    logic [W-1:0]  x;
    logic [EW-1:0] e;
    int            lat;
    logic [W-1:0]  res;
    int            mp, ms;
    bit            pb, pd, inj;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int cyc, nd;
    logic [W-1:0] prev;
    tbl[0] = '{16'd2,  8'h0B, 1, 16'd7, 13, 9,  0, 0, 0};
    tbl[1] = '{16'd5,  8'h00, 1, 16'd1, 10, 1,  0, 0, 0};
    tbl[2] = '{16'd0,  8'h05, 2, 16'd0, 12, 7,  0, 0, 0};
    tbl[3] = '{16'd12, 8'h02, 1, 16'd1, 11, 5,  0, 0, 0};
    tbl[4] = '{16'd2,  8'h0B, 0, 16'd7, 13, 9,  0, 0, 0};
    tbl[5] = '{16'd2,  8'hFF, 1, 16'd8, 18, 18, 0, 0, 0};
    tbl[6] = '{16'd12, 8'h80, 3, 16'd1, 11, 11, 0, 0, 0};
    tbl[7] = '{16'd2,  8'h0B, 3, 16'd7, 13, 9,  1, 1, 1};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_m", mul_m, 0);
    chk("rst_mul_err", mul_err, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_start", mul_start, 0);

    prev = '0;
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].x, tbl[i].e, tbl[i].lat, tbl[i].pb, tbl[i].pd, tbl[i].inj,
             prev, tbl[i].res, SKIP ? tbl[i].ms : tbl[i].mp, tbl[i].inj);
      prev = tbl[i].res;
    end

    // Abort during the 4th multiply wait; the outstanding multiply completes late into IDLE.
    lat_cfg = 5;
    @(negedge clk);
    nstart = 0;
    in_x = 16'd2;
    in_e = 8'h0B;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (nstart < 4 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_4th_mul", nstart, 4);
    @(negedge clk);
    chk("in_4th_wait", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_mul_start", mul_start, 0);
    chk("abort_mul_a", mul_a, 0);
    chk("abort_mul_b", mul_b, 0);
    chk("abort_mul_m", mul_m, 0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) cyc++;
    end
    chk("no_done_after_abort", nd, 0);
    chk("late_mul_done_ignored", cyc, 0);
    run_op(16'd3, 8'h03, 2, 0, 0, 0, 16'd0, 16'd1, SKIP ? 6 : 12, 0);

    chk("no_overlapping_starts", proto_err, 0);
    chk("operands_stable", stab_err, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
